// File: rtl/pk_reader_pkg.sv
// Shared types and constants for the pk_reader step-memory streamer.
package pk_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    // Keeps address ports at least one bit wide for degenerate depths.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pk_rd_fifo.sv
// Four-entry first-word-fall-through buffer with occupancy output.
module pk_rd_fifo
    import pk_reader_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       push_data,
    input  logic               pop,
    output logic [W-1:0]       dout,
    output logic               valid,
    output logic [FIFO_CW-1:0] count
);

    logic [W-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic               pop_ok;
    logic               push_ok;

    assign valid   = (count != '0);
    assign dout    = valid ? mem[rd_ptr] : '0;
    assign pop_ok  = pop && valid;
    assign push_ok = push && ((count != FIFO_CW'(FIFO_DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + FIFO_CW'(1);
                2'b01:   count <= count - FIFO_CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pk_reader.sv
// Streams a block of words from the step data memory through a small FWFT buffer.
// Optional running XOR checksum output enabled by PK_READER_CHECKSUM_EN.
module pk_reader
    import pk_reader_pkg::*;
#(
    parameter  int unsigned M  = 1,
    parameter  int unsigned N  = 4,
    parameter  int unsigned L  = 8,
    parameter  int unsigned K  = 16,
    localparam int unsigned W  = N * M,
    localparam int unsigned D  = L * K / N,
    localparam int unsigned AW = clog2_min1(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_count,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [W-1:0]  mem_data_in,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready
`ifdef PK_READER_CHECKSUM_EN
    , output logic [W-1:0] checksum
`endif
);

    state_t               state;
    logic                 inflight;
    logic [AW:0]          rd_left;
    logic [AW:0]          words_left;
    logic [FIFO_CW-1:0]   fifo_count;
    logic                 hs;
    logic                 can_issue;
    logic [AW-1:0]        next_addr;

    pk_rd_fifo #(.W(W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (mem_data_in),
        .pop       (hs),
        .dout      (dout),
        .valid     (dout_valid),
        .count     (fifo_count)
    );

    assign hs        = dout_valid && dout_ready;
    assign next_addr = (mem_rd_addr == AW'(D - 1)) ? '0 : mem_rd_addr + AW'(1);
    // The read being decided lands two edges later, so the strobe already
    // on the bus is counted alongside buffered and in-flight words.
    assign can_issue = (32'(fifo_count) + 32'(inflight) + 32'(mem_rd_en)) < FIFO_DEPTH;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            inflight    <= 1'b0;
            rd_left     <= '0;
            words_left  <= '0;
        end else begin
            inflight <= mem_rd_en;
            if (hs) begin
                words_left <= words_left - (AW+1)'(1);
            end
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    mem_rd_en <= 1'b0;
                    if (start && !busy) begin
                        busy <= 1'b1;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= (word_count == (AW+1)'(1)) ? DRAIN : READ;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= base_addr;
                            rd_left     <= word_count - (AW+1)'(1);
                            words_left  <= word_count;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                READ: begin
                    if (can_issue) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= next_addr;
                        rd_left     <= rd_left - (AW+1)'(1);
                        if (rd_left == (AW+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    mem_rd_en <= 1'b0;
                    if (hs && (words_left == (AW+1)'(1))) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PK_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum <= '0;
        end else if ((state == IDLE) && start && !busy) begin
            checksum <= '0;
        end else if (hs) begin
            checksum <= checksum ^ dout;
        end
    end
`else
    // Default build carries no checksum accumulator.
`endif

endmodule

// File: tb/tb_pk_reader.sv
// Self-checking bench for pk_reader (N=4, M=1, L=8, K=16 -> D=32, W=4).
// Checksum scenario is compiled only when PK_READER_CHECKSUM_EN is defined.
module tb_pk_reader;

    localparam int unsigned D = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] word_count;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [4:0] mem_rd_addr;
    logic [3:0] mem_data_in;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
`ifdef PK_READER_CHECKSUM_EN
    logic [3:0] checksum;
`endif

    int vectors = 0;
    int miscompares = 0;

    pk_reader #(.M(1), .N(4), .L(8), .K(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_data_in (mem_data_in),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready)
`ifdef PK_READER_CHECKSUM_EN
        , .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Step data memory: one-cycle read latency.
    logic [3:0] mem [D];
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_data_in <= mem[mem_rd_addr];
    end

    // Per-transfer observations filled by do_xfer.
    logic [4:0] rd_q[$];
    logic [3:0] got_q[$];
    int first_valid, done_cyc, last_hs, max_out, unstable, valid_seen, busy_gap;
    logic busy_after;

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < int'(D); i++) mem[i] = ramp ? 4'(i) : 4'($urandom);
    endtask

    // rmode: 0 ready always 1, 1 ready toggles 1,0,..., 2 random ready.
    task automatic do_xfer(input int b, input int n, input int rmode, input bit poke);
        int issued, hs_n;
        bit prev_stall;
        logic [3:0] prev_dout;
        rd_q.delete();
        got_q.delete();
        first_valid = -1; done_cyc = -1; last_hs = -1; max_out = 0;
        unstable = 0; valid_seen = 0; busy_gap = 0; busy_after = 1'b1;
        issued = 0; hs_n = 0; prev_stall = 0; prev_dout = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 5'(b); word_count = 6'(n);
        @(posedge clk); #1;
        start = 1'b0; base_addr = 5'($urandom); word_count = 6'($urandom);
        for (int c = 1; c <= 400; c++) begin
            start = 1'b0;
            if (done_cyc >= 0) begin
                busy_after = busy;
                break;
            end
            if (mem_rd_en) begin
                rd_q.push_back(mem_rd_addr);
                issued++;
            end
            if (issued - hs_n > max_out) max_out = issued - hs_n;
            if (prev_stall && (!dout_valid || dout !== prev_dout)) unstable++;
            if (dout_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = c;
            end
            if (!busy) busy_gap++;
            if (done) done_cyc = c;
            case (rmode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = c[0];
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && c == 4) start = 1'b1;
            if (dout_valid && dout_ready) begin
                got_q.push_back(dout);
                hs_n++;
                last_hs = c;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            @(posedge clk); #1;
        end
        dout_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dout_ready = 1'b0; base_addr = '0; word_count = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, mem_rd_en, dout_valid, mem_rd_addr, dout} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, mem_rd_en, dout_valid, mem_rd_addr, dout});
        end
        rst = 1'b1;
    endtask

    task automatic test_full_sweep();
        fill_mem(0);
        do_xfer(0, 32, 0, 0);
        vectors++;
        if (got_q.size() !== 32) begin
            miscompares++;
            $display("FAIL sweep_count: got %0d expected 32", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 32; i++) begin
            vectors++;
            if (got_q[i] !== mem[i]) begin
                miscompares++;
                $display("FAIL sweep_word[%0d]: got %h expected %h", i, got_q[i], mem[i]);
            end
        end
        vectors++;
        if (first_valid !== 3) begin
            miscompares++;
            $display("FAIL sweep_first_valid: got T+%0d expected T+3", first_valid);
        end
        vectors++;
        if (done_cyc !== 35 || last_hs - first_valid !== 31) begin
            miscompares++;
            $display("FAIL sweep_timing: got done T+%0d span %0d expected T+35 span 31",
                     done_cyc, last_hs - first_valid);
        end
        vectors++;
        if (busy_gap !== 0 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_busy: got gaps %0d after %b expected 0 0", busy_gap, busy_after);
        end
    endtask

    task automatic test_wrap();
        fill_mem(0);
        do_xfer(30, 4, 2, 0);
        vectors++;
        if (rd_q.size() !== 4 || got_q.size() !== 4) begin
            miscompares++;
            $display("FAIL wrap_count: got reads %0d words %0d expected 4 4", rd_q.size(), got_q.size());
        end
        for (int i = 0; i < 4 && i < rd_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (rd_q[i] !== 5'((30 + i) % 32) || got_q[i] !== mem[(30 + i) % 32]) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, rd_q[i], got_q[i], (30 + i) % 32, mem[(30 + i) % 32]);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_mem(0);
        do_xfer(0, 16, 1, 0);
        vectors++;
        if (got_q.size() !== 16) begin
            miscompares++;
            $display("FAIL bp_count: got %0d expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            vectors++;
            if (got_q[i] !== mem[i]) begin
                miscompares++;
                $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], mem[i]);
            end
        end
        vectors++;
        if (max_out > 4 || unstable !== 0) begin
            miscompares++;
            $display("FAIL bp_occupancy: got max %0d unstable %0d expected <=4 and 0", max_out, unstable);
        end
        vectors++;
        if (done_cyc !== last_hs + 1) begin
            miscompares++;
            $display("FAIL bp_done: got T+%0d expected T+%0d", done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_zero_count();
        do_xfer($urandom_range(0, 31), 0, 0, 0);
        vectors++;
        if (done_cyc !== 1 || busy_after !== 1'b0 || busy_gap !== 0) begin
            miscompares++;
            $display("FAIL zero_done: got done T+%0d busy_after %b gaps %0d expected T+1 0 0",
                     done_cyc, busy_after, busy_gap);
        end
        vectors++;
        if (rd_q.size() !== 0 || valid_seen !== 0) begin
            miscompares++;
            $display("FAIL zero_activity: got reads %0d valids %0d expected 0 0", rd_q.size(), valid_seen);
        end
    endtask

    task automatic test_mid_reset();
        int hs_n, stray;
        fill_mem(0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; word_count = 6'd32;
        @(posedge clk); #1;
        start = 1'b0; dout_ready = 1'b1; hs_n = 0;
        for (int c = 0; c < 100; c++) begin
            if (dout_valid) hs_n++;
            if (hs_n == 5) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (hs_n !== 5) begin
            miscompares++;
            $display("FAIL mreset_reach: got %0d words expected 5", hs_n);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; dout_ready = 1'b0;
        vectors++;
        if ({busy, done, mem_rd_en, dout_valid, mem_rd_addr, dout} !== 13'd0) begin
            miscompares++;
            $display("FAIL mreset_outputs: got %b expected all zero",
                     {busy, done, mem_rd_en, dout_valid, mem_rd_addr, dout});
        end
`ifdef PK_READER_CHECKSUM_EN
        vectors++;
        if (checksum !== 4'd0) begin
            miscompares++;
            $display("FAIL mreset_checksum: got %h expected 0", checksum);
        end
`endif
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            if (dout_valid || busy || mem_rd_en) stray++;
            @(posedge clk); #1;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL mreset_stray: got %0d active cycles expected 0", stray);
        end
        do_xfer(8, 2, 0, 0);
        vectors++;
        if (got_q.size() !== 2 || done_cyc !== last_hs + 1) begin
            miscompares++;
            $display("FAIL mreset_after: got %0d words done T+%0d expected 2 words done T+%0d",
                     got_q.size(), done_cyc, last_hs + 1);
        end else begin
            vectors++;
            if (got_q[0] !== mem[8] || got_q[1] !== mem[9]) begin
                miscompares++;
                $display("FAIL mreset_data: got %h %h expected %h %h", got_q[0], got_q[1], mem[8], mem[9]);
            end
        end
    endtask

    task automatic test_random();
        int b, n, bad;
        for (int it = 0; it < 10; it++) begin
            b = $urandom_range(0, 31);
            n = $urandom_range(1, 32);
            fill_mem(0);
            do_xfer(b, n, 2, 1'($urandom_range(0, 1)));
            vectors++;
            if (got_q.size() !== n || rd_q.size() !== n) begin
                miscompares++;
                $display("FAIL rand_count: got words %0d reads %0d expected %0d (base %0d)",
                         got_q.size(), rd_q.size(), n, b);
            end
            bad = 0;
            for (int i = 0; i < n && i < got_q.size() && i < rd_q.size(); i++) begin
                if (got_q[i] !== mem[(b + i) % 32] || rd_q[i] !== 5'((b + i) % 32)) bad++;
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL rand_stream: got %0d wrong words expected 0 (base %0d count %0d)", bad, b, n);
            end
            vectors++;
            if (max_out > 4 || unstable !== 0 || first_valid !== 3) begin
                miscompares++;
                $display("FAIL rand_flow: got max %0d unstable %0d first T+%0d expected <=4 0 T+3",
                         max_out, unstable, first_valid);
            end
            vectors++;
            if (done_cyc !== last_hs + 1 || busy_gap !== 0 || busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_done: got done T+%0d gaps %0d after %b expected T+%0d 0 0",
                         done_cyc, busy_gap, busy_after, last_hs + 1);
            end
        end
    endtask

`ifdef PK_READER_CHECKSUM_EN
    task automatic test_checksum();
        fill_mem(1);
        do_xfer(0, 3, 0, 0);
        vectors++;
        if (checksum !== 4'd3) begin
            miscompares++;
            $display("FAIL checksum_3: got %h expected 3", checksum);
        end
        do_xfer(0, 16, 2, 0);
        vectors++;
        if (checksum !== 4'd0) begin
            miscompares++;
            $display("FAIL checksum_16: got %h expected 0", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_mid_reset();
        test_random();
`ifdef PK_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
